// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared types and constants for the pipeline hazard unit
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MDU_WAIT = 2'b01,
        REDIRECT = 2'b10
    } hz_state_t;

    localparam int ZERO_REG = '0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - per-operand EX forwarding select, M result beats W result
module hazard_fwd_sel
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_w,
    input  logic [REG_AW-1:0] rd_w,
    input  logic [REG_AW-1:0] rs,
    output fwd_sel_t          sel
);

    logic hit_m;
    logic hit_w;

    // x0 is hard-wired zero, so a write to it must never be forwarded
    assign hit_m = reg_write_m && (rd_m != REG_AW'(ZERO_REG)) && (rd_m == rs);
    assign hit_w = reg_write_w && (rd_w != REG_AW'(ZERO_REG)) && (rd_w == rs);

    always_comb begin
        sel = FWD_RF;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - forwarding, load-use stall, MDU wait and redirect flush control
module hazard_ctrl_unit
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16,
    parameter int MDU_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemReadE,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [REG_AW-1:0] RD_W,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic              PCSrcE,
    input  logic              MduStartE,
    input  logic              MduDone,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MduTimeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int TCW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam int RCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    hz_state_t      state, state_n;
    logic [TCW-1:0] tcnt, tcnt_n;
    logic [RCW-1:0] rcnt, rcnt_n;
    fwd_sel_t       fwd_a, fwd_b;
    logic           lu;
    logic           stall_fe, stall_ex, flush_de, flush_ex, flush_mem, timeout;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .reg_write_m (RegWriteM),
        .rd_m        (RD_M),
        .reg_write_w (RegWriteW),
        .rd_w        (RD_W),
        .rs          (Rs1_E),
        .sel         (fwd_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .reg_write_m (RegWriteM),
        .rd_m        (RD_M),
        .reg_write_w (RegWriteW),
        .rd_w        (RD_W),
        .rs          (Rs2_E),
        .sel         (fwd_b)
    );

    assign lu = MemReadE && (RD_E != REG_AW'(ZERO_REG)) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt;
        rcnt_n    = rcnt;
        stall_fe  = 1'b0;
        stall_ex  = 1'b0;
        flush_de  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            RUN: begin
                // A taken branch squashes whatever else E claims to be doing
                if (PCSrcE) begin
                    flush_de = 1'b1;
                    flush_ex = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_n = REDIRECT;
                        rcnt_n  = RCW'(FLUSH_CYCLES - 1);
                    end
                end else if (MduStartE && !MduDone) begin
                    stall_fe  = 1'b1;
                    stall_ex  = 1'b1;
                    flush_mem = 1'b1;
                    state_n   = MDU_WAIT;
                    tcnt_n    = '0;
                end else if (lu) begin
                    stall_fe = 1'b1;
                    flush_ex = 1'b1;
                end
            end
            MDU_WAIT: begin
                stall_fe  = 1'b1;
                stall_ex  = 1'b1;
                flush_mem = 1'b1;
                if (MduDone) begin
                    state_n = RUN;
                end else if ((MDU_TIMEOUT != 0) && (tcnt == TCW'(MDU_TIMEOUT - 1))) begin
                    timeout = 1'b1;
                    state_n = RUN;
                end else begin
                    tcnt_n = tcnt + TCW'(1);
                end
            end
            REDIRECT: begin
                flush_de = 1'b1;
                if (rcnt <= RCW'(1)) begin
                    state_n = RUN;
                    rcnt_n  = '0;
                end else begin
                    rcnt_n = rcnt - RCW'(1);
                end
            end
            default: state_n = RUN;
        endcase
    end

    assign ForwardAE  = rst ? fwd_a : FWD_RF;
    assign ForwardBE  = rst ? fwd_b : FWD_RF;
    assign StallF     = rst & stall_fe;
    assign StallD     = rst & stall_fe;
    assign StallE     = rst & stall_ex;
    assign FlushD     = rst & flush_de;
    assign FlushE     = rst & flush_ex;
    assign FlushM     = rst & flush_mem;
    assign MduTimeout = rst & timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            tcnt      <= '0;
            rcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
            rcnt  <= rcnt_n;
            if (StallF && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((FlushD || FlushE) && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
